multi_nch_disp: RTL

MULTI_NCH_DISP -- requirements
Module: multi_nch_disp

---
 rtl/multi_nch_disp.sv | 123 ++++++++++++
 1 files changed

// File: rtl/multi_nch_disp.sv
`default_nettype none
// ============================================================================
// Module   : multi_nch_disp
// Brief    : Multi-channel display selector with manual select, timed
//            auto-scan and optional blink gating (macro MULTI_NCH_BLINK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module multi_nch_disp #(
    parameter int CH        = 8,
    parameter int W         = 32,
    parameter int DWELL     = 4,
    parameter int BLINK_DIV = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      EN,
    input  logic                      auto,
    input  logic [$clog2(CH)-1:0]     Test,
    input  logic [CH*W-1:0]           data_in,
    input  logic [CH*(W/4)-1:0]       point_in,
    input  logic [CH*(W/4)-1:0]       blink_in,
    output logic [W-1:0]              Disp_num,
    output logic [W/4-1:0]            point_out,
    output logic [W/4-1:0]            blink_out,
    output logic [$clog2(CH)-1:0]     ch_sel,
    output logic                      upd
);

    localparam int SEG = W / 4;
    localparam int SW  = $clog2(CH);
    localparam int DW  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] c_DWELL_LAST = DW'(DWELL - 1);

    logic [SW-1:0]  r_ch_sel;
    logic [DW-1:0]  r_dwell;
    logic           r_prev_auto;
    logic           r_upd;
    logic [W-1:0]   r_disp;
    logic [SEG-1:0] r_point;
    logic [SEG-1:0] r_blink_raw;

    logic [SW-1:0]  w_next_sel;
    logic [DW-1:0]  w_next_dwell;
    logic           w_next_upd;

    // Next channel: Test in manual mode or on auto entry, else dwell-timed advance
    always_comb begin
        w_next_sel   = r_ch_sel;
        w_next_dwell = r_dwell;
        w_next_upd   = 1'b0;
        if (!auto) begin
            w_next_sel = Test;
            w_next_upd = (Test != r_ch_sel);
        end else if (!r_prev_auto) begin
            w_next_sel   = Test;
            w_next_dwell = '0;
            w_next_upd   = 1'b1;
        end else if (r_dwell == c_DWELL_LAST) begin
            w_next_sel   = r_ch_sel + 1'b1;
            w_next_dwell = '0;
            w_next_upd   = 1'b1;
        end else begin
            w_next_dwell = r_dwell + 1'b1;
        end
    end

    // Outputs are reloaded from the chosen channel every enabled clock so live data is tracked
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch_sel    <= '0;
            r_dwell     <= '0;
            r_prev_auto <= 1'b0;
            r_upd       <= 1'b0;
            r_disp      <= '0;
            r_point     <= '0;
            r_blink_raw <= '0;
        end else if (EN) begin
            r_ch_sel    <= w_next_sel;
            r_dwell     <= w_next_dwell;
            r_prev_auto <= auto;
            r_upd       <= w_next_upd;
            r_disp      <= data_in[w_next_sel*W +: W];
            r_point     <= point_in[w_next_sel*SEG +: SEG];
            r_blink_raw <= blink_in[w_next_sel*SEG +: SEG];
        end else begin
            r_upd       <= 1'b0;
        end
    end

`ifdef MULTI_NCH_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] c_BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;

    // Phase starts blank and toggles every BLINK_DIV enabled clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (EN) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign blink_out = r_blink_raw & {SEG{r_phase}};
`else
    assign blink_out = r_blink_raw;
`endif

    assign Disp_num  = r_disp;
    assign point_out = r_point;
    assign ch_sel    = r_ch_sel;
    assign upd       = r_upd;

endmodule
`default_nettype wire
